// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexing scan controller for a common-anode seven-segment display.
// A single external hex-to-7-segment decoder is shared by all digits: the
// controller presents one nibble at a time on nib_out, samples the decoder's
// active-low abcdefg result on seg_in, and walks the active-low anodes with a
// dead window at the start of every digit slot so that the decoder and the
// anode drivers settle without ghosting.
//
// The displayed value is double-buffered: a load strobe captures the next
// value into a pending buffer, which is promoted to the active buffer only at
// the frame wrap. That way a frame never shows a mix of old and new digits.
//
// Optional build feature (macro SEG_SCAN_LZ_BLANK_EN):
//   When defined, leading zeros are suppressed. At each wrap, every digit other
//   than digit 0 is darkened if it and all higher digits are zero. This dark
//   set is ORed with the active blank mask.
//   When undefined, only blank_mask and en darken digits.
//
// Parameters:
//   NUM_DIGITS   digits scanned (2..8)
//   REFRESH_DIV  clock cycles per digit slot (> DEAD_CYCLES)
//   DEAD_CYCLES  anodes-off cycles at the start of each slot (>= 2)
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   en          display enable; 0 keeps anodes off while scanning continues
//   load        one-cycle strobe capturing value / blank_mask
//   value       digit nibbles, digit 0 = bits [3:0]
//   blank_mask  1 = digit forced dark
//   nib_out     nibble for the shared decoder
//   seg_in      decoder result, active-low abcdefg
//   seg         segment pins, active-low abcdefg (registered)
//   an          anode pins, active-low (registered)
//   frame       one-cycle pulse after the digit-index wrap
//   pending     1 = a loaded value is waiting for the next wrap
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              nib_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame,
  output logic                    pending
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  // Position inside a digit slot.
  typedef enum logic {
    PH_DEAD,
    PH_SHOW
  } phase_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [VAL_W-1:0]      r_act_val;
  logic [NUM_DIGITS-1:0] r_act_mask;
  logic [VAL_W-1:0]      r_pend_val;
  logic [NUM_DIGITS-1:0] r_pend_mask;
  logic                  r_pending;
  logic [3:0]            r_nib;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame;

  // ---------------------------------------------------------------------------
  // Combinational next-state
  // ---------------------------------------------------------------------------
  phase_t                w_phase;
  logic                  w_slot_end;
  logic                  w_last_digit;
  logic                  w_wrap;
  logic [CNT_W-1:0]      w_cnt_nx;
  logic [IDX_W-1:0]      w_idx_nx;
  logic [VAL_W-1:0]      w_act_val_nx;
  logic [NUM_DIGITS-1:0] w_act_mask_nx;
  logic [3:0]            w_nib_nx;
  logic [NUM_DIGITS-1:0] w_dark;
  logic                  w_digit_off;
  logic [6:0]            w_seg_nx;
  logic [NUM_DIGITS-1:0] w_an_nx;

  // Slot counter and digit index.
  always_comb begin
    w_slot_end   = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    w_last_digit = (r_idx == IDX_W'(NUM_DIGITS - 1));
    w_wrap       = w_slot_end & w_last_digit;

    w_cnt_nx = w_slot_end ? '0 : r_cnt + 1'b1;

    w_idx_nx = r_idx;
    if (w_slot_end) begin
      w_idx_nx = w_last_digit ? '0 : r_idx + 1'b1;
    end

    w_phase = (r_cnt >= CNT_W'(DEAD_CYCLES)) ? PH_SHOW : PH_DEAD;
  end

  // Active buffer promotion. A load landing on the wrap edge bypasses the
  // pending buffer and supersedes whatever was pending.
  always_comb begin
    w_act_val_nx  = r_act_val;
    w_act_mask_nx = r_act_mask;
    if (w_wrap) begin
      if (load) begin
        w_act_val_nx  = value;
        w_act_mask_nx = blank_mask;
      end else if (r_pending) begin
        w_act_val_nx  = r_pend_val;
        w_act_mask_nx = r_pend_mask;
      end
    end
  end

  // The decoder gets the nibble of the digit about to be scanned, taken from
  // the buffer that will be active for it, so the dead window covers the
  // decoder's settling time.
  always_comb begin
    w_nib_nx = r_nib;
    if (w_slot_end) begin
      w_nib_nx = w_act_val_nx[{w_idx_nx, 2'b00} +: 4];
    end
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] r_lz_dark;
  logic [NUM_DIGITS-1:0] w_lz_nx;
  logic                  w_zero_above;

  // Walk from the most significant digit down; a digit goes dark while every
  // nibble from the top down to it is zero. Digit 0 is never suppressed.
  always_comb begin
    w_lz_nx      = '0;
    w_zero_above = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      w_zero_above = w_zero_above &
                     (w_act_val_nx[(NUM_DIGITS - 1 - k) * 4 +: 4] == 4'h0);
      w_lz_nx[NUM_DIGITS - 1 - k] = w_zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lz_dark <= '0;
    end else if (w_wrap) begin
      r_lz_dark <= w_lz_nx;
    end
  end

  always_comb begin
    w_dark = r_act_mask | r_lz_dark;
  end
`else
  always_comb begin
    w_dark = r_act_mask;
  end
`endif

  // Pin drive for the slot currently being processed.
  always_comb begin
    w_digit_off = ~en | w_dark[r_idx];
    w_seg_nx    = '1;
    w_an_nx     = '1;
    if ((w_phase == PH_SHOW) && !w_digit_off) begin
      w_seg_nx = seg_in;
      w_an_nx  = ~(NUM_DIGITS'(1) << r_idx);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_act_val   <= '0;
      r_act_mask  <= '0;
      r_pend_val  <= '0;
      r_pend_mask <= '0;
      r_pending   <= 1'b0;
      r_nib       <= '0;
      r_seg       <= '1;
      r_an        <= '1;
      r_frame     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nx;
      r_idx      <= w_idx_nx;
      r_act_val  <= w_act_val_nx;
      r_act_mask <= w_act_mask_nx;
      r_nib      <= w_nib_nx;
      r_seg      <= w_seg_nx;
      r_an       <= w_an_nx;
      r_frame    <= w_wrap;

      // Any wrap consumes the pending buffer (or is overridden by a direct
      // load); otherwise a load overwrites it, so the last load in a frame wins.
      if (w_wrap) begin
        r_pending <= 1'b0;
      end else if (load) begin
        r_pend_val  <= value;
        r_pend_mask <= blank_mask;
        r_pending   <= 1'b1;
      end
    end
  end

  assign nib_out = r_nib;
  assign seg     = r_seg;
  assign an      = r_an;
  assign frame   = r_frame;
  assign pending = r_pending;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8,
// DEAD_CYCLES=2 and a behavioural hex-to-7-segment decoder on nib_out/seg_in.
// n_edge counts clock edges since the last reset edge; with these parameters
// edge n processes slot phase (n-1)%8 of digit ((n-1)/8)%4, the digit's anode
// is low after edges with phase >= 2, and wrap edges are multiples of 32.
// Build with +define+SEG_SCAN_LZ_BLANK_EN to exercise leading-zero blanking.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int DC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic [3:0]  nib_out;
  logic [6:0]  seg_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame;
  logic        pending;

  int errors = 0;
  int checks = 0;
  int n_edge = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .DEAD_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .value     (value),
    .blank_mask(blank_mask),
    .nib_out   (nib_out),
    .seg_in    (seg_in),
    .seg       (seg),
    .an        (an),
    .frame     (frame),
    .pending   (pending)
  );

  // Shared external decoder: active-low abcdefg.
  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  always_comb seg_in = dec7(nib_out);

  task automatic tick();
    @(posedge clk);
    #1;
    n_edge++;
  endtask

  task automatic run_to(input int target);
    while (n_edge < target) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] m);
    value      = v;
    blank_mask = m;
    load       = 1'b1;
    tick();
    load       = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b0; value = 16'hFFFF; blank_mask = 4'hF;
    tick();
    tick();
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rst_an: got %b expected %b", an, 4'b1111); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL rst_seg: got %b expected %b", seg, 7'b1111111); end
    checks++; if (nib_out !== 4'h0) begin errors++; $display("FAIL rst_nib: got %h expected %h", nib_out, 4'h0); end
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL rst_frame: got %b expected %b", frame, 1'b0); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rst_pending: got %b expected %b", pending, 1'b0); end
    rst = 1'b0;
    blank_mask = 4'h0;
    n_edge = 0;
  endtask

  // First frame after reset: value 0, nothing masked.
  task automatic test_scan();
    logic [3:0] ea;
    logic [6:0] es;
    for (int n = 1; n <= 32; n++) begin
      tick();
      ea = 4'b1111;
      es = 7'b1111111;
      if ((n - 1) % 8 >= 2) begin
        ea[(n - 1) / 8] = 1'b0;
        es = 7'b0000001;
      end
      checks++; if (an !== ea) begin errors++; $display("FAIL scan_an@%0d: got %b expected %b", n, an, ea); end
      checks++; if (seg !== es) begin errors++; $display("FAIL scan_seg@%0d: got %b expected %b", n, seg, es); end
      checks++; if (frame !== (n == 32)) begin errors++; $display("FAIL scan_frame@%0d: got %b expected %b", n, frame, (n == 32)); end
    end
  endtask

  task automatic test_load_midframe();
    run_to(35);
    checks++; if (seg !== 7'b0000001) begin errors++; $display("FAIL mid_old_seg: got %b expected %b", seg, 7'b0000001); end
    run_to(36);
    do_load(16'h1234, 4'b0000);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL mid_pend_set: got %b expected %b", pending, 1'b1); end
    checks++; if (nib_out !== 4'h0) begin errors++; $display("FAIL mid_nib_hold: got %h expected %h", nib_out, 4'h0); end
    run_to(63);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL mid_pend_hold: got %b expected %b", pending, 1'b1); end
    tick();
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL mid_pend_clr: got %b expected %b", pending, 1'b0); end
    checks++; if (frame !== 1'b1) begin errors++; $display("FAIL mid_frame: got %b expected %b", frame, 1'b1); end
    run_to(67);
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL mid_d0_an: got %b expected %b", an, 4'b1110); end
    checks++; if (seg !== 7'b1001100) begin errors++; $display("FAIL mid_d0_seg: got %b expected %b", seg, 7'b1001100); end
    run_to(75);
    checks++; if (seg !== 7'b0000110) begin errors++; $display("FAIL mid_d1_seg: got %b expected %b", seg, 7'b0000110); end
    run_to(83);
    checks++; if (seg !== 7'b0010010) begin errors++; $display("FAIL mid_d2_seg: got %b expected %b", seg, 7'b0010010); end
    run_to(91);
    checks++; if (an !== 4'b0111) begin errors++; $display("FAIL mid_d3_an: got %b expected %b", an, 4'b0111); end
    checks++; if (seg !== 7'b1001111) begin errors++; $display("FAIL mid_d3_seg: got %b expected %b", seg, 7'b1001111); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ea;
    run_to(91);
    do_load(16'hAAAA, 4'b0000);
    run_to(93);
    do_load(16'h5555, 4'b0000);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL b2b_pend: got %b expected %b", pending, 1'b1); end
    run_to(96);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL b2b_pend_clr: got %b expected %b", pending, 1'b0); end
    for (int d = 0; d < 4; d++) begin
      run_to(96 + 8 * d + 3);
      ea = 4'b1111;
      ea[d] = 1'b0;
      checks++; if (an !== ea) begin errors++; $display("FAIL b2b_an_d%0d: got %b expected %b", d, an, ea); end
      checks++; if (seg !== 7'b0100100) begin errors++; $display("FAIL b2b_seg_d%0d: got %b expected %b", d, seg, 7'b0100100); end
    end
  endtask

  task automatic test_load_on_wrap();
    run_to(127);
    do_load(16'h00F0, 4'b0000);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL wrap_pend: got %b expected %b", pending, 1'b0); end
    checks++; if (frame !== 1'b1) begin errors++; $display("FAIL wrap_frame: got %b expected %b", frame, 1'b1); end
    run_to(131);
    checks++; if (seg !== 7'b0000001) begin errors++; $display("FAIL wrap_d0_seg: got %b expected %b", seg, 7'b0000001); end
    run_to(136);
    checks++; if (nib_out !== 4'hF) begin errors++; $display("FAIL wrap_d1_nib: got %h expected %h", nib_out, 4'hF); end
    run_to(139);
    checks++; if (an !== 4'b1101) begin errors++; $display("FAIL wrap_d1_an: got %b expected %b", an, 4'b1101); end
    checks++; if (seg !== 7'b0111000) begin errors++; $display("FAIL wrap_d1_seg: got %b expected %b", seg, 7'b0111000); end
  endtask

  task automatic test_blank_mask();
    run_to(139);
    do_load(16'h1234, 4'b0101);
    run_to(163);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL mask_d0_an: got %b expected %b", an, 4'b1111); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL mask_d0_seg: got %b expected %b", seg, 7'b1111111); end
    run_to(171);
    checks++; if (an !== 4'b1101) begin errors++; $display("FAIL mask_d1_an: got %b expected %b", an, 4'b1101); end
    checks++; if (seg !== 7'b0000110) begin errors++; $display("FAIL mask_d1_seg: got %b expected %b", seg, 7'b0000110); end
    run_to(179);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL mask_d2_an: got %b expected %b", an, 4'b1111); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL mask_d2_seg: got %b expected %b", seg, 7'b1111111); end
    run_to(187);
    checks++; if (an !== 4'b0111) begin errors++; $display("FAIL mask_d3_an: got %b expected %b", an, 4'b0111); end
    checks++; if (seg !== 7'b1001111) begin errors++; $display("FAIL mask_d3_seg: got %b expected %b", seg, 7'b1001111); end
  endtask

  task automatic test_enable();
    int bad_an;
    int bad_seg;
    int pulses;
    int pulse_at;
    bad_an = 0; bad_seg = 0; pulses = 0; pulse_at = -1;
    do_load(16'h1234, 4'b0000);
    run_to(192);
    en = 1'b0;
    for (int n = 193; n <= 224; n++) begin
      tick();
      if (an !== 4'b1111) bad_an++;
      if (seg !== 7'b1111111) bad_seg++;
      if (frame === 1'b1) begin pulses++; pulse_at = n; end
    end
    checks++; if (bad_an != 0) begin errors++; $display("FAIL en0_an_lit_cycles: got %0d expected %0d", bad_an, 0); end
    checks++; if (bad_seg != 0) begin errors++; $display("FAIL en0_seg_lit_cycles: got %0d expected %0d", bad_seg, 0); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL en0_frame_count: got %0d expected %0d", pulses, 1); end
    checks++; if (pulse_at != 224) begin errors++; $display("FAIL en0_frame_edge: got %0d expected %0d", pulse_at, 224); end
    en = 1'b1;
    run_to(227);
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL en1_an: got %b expected %b", an, 4'b1110); end
    checks++; if (seg !== 7'b1001100) begin errors++; $display("FAIL en1_seg: got %b expected %b", seg, 7'b1001100); end
  endtask

`ifdef SEG_SCAN_LZ_BLANK_EN
  task automatic test_lz_blank();
    run_to(227);
    do_load(16'h0007, 4'b0000);
    run_to(259);
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL lz7_d0_an: got %b expected %b", an, 4'b1110); end
    checks++; if (seg !== 7'b0001111) begin errors++; $display("FAIL lz7_d0_seg: got %b expected %b", seg, 7'b0001111); end
    for (int d = 1; d < 4; d++) begin
      run_to(256 + 8 * d + 3);
      checks++; if (an !== 4'b1111) begin errors++; $display("FAIL lz7_d%0d_an: got %b expected %b", d, an, 4'b1111); end
      checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL lz7_d%0d_seg: got %b expected %b", d, seg, 7'b1111111); end
    end
    do_load(16'h0000, 4'b0000);
    run_to(291);
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL lz0_d0_an: got %b expected %b", an, 4'b1110); end
    checks++; if (seg !== 7'b0000001) begin errors++; $display("FAIL lz0_d0_seg: got %b expected %b", seg, 7'b0000001); end
    run_to(299);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL lz0_d1_an: got %b expected %b", an, 4'b1111); end
  endtask
`else
  task automatic test_zeros_shown();
    run_to(227);
    do_load(16'h0007, 4'b0000);
    run_to(259);
    checks++; if (seg !== 7'b0001111) begin errors++; $display("FAIL z7_d0_seg: got %b expected %b", seg, 7'b0001111); end
    run_to(267);
    checks++; if (an !== 4'b1101) begin errors++; $display("FAIL z7_d1_an: got %b expected %b", an, 4'b1101); end
    checks++; if (seg !== 7'b0000001) begin errors++; $display("FAIL z7_d1_seg: got %b expected %b", seg, 7'b0000001); end
    run_to(283);
    checks++; if (an !== 4'b0111) begin errors++; $display("FAIL z7_d3_an: got %b expected %b", an, 4'b0111); end
    do_load(16'h0000, 4'b0000);
    run_to(291);
    checks++; if (seg !== 7'b0000001) begin errors++; $display("FAIL z0_d0_seg: got %b expected %b", seg, 7'b0000001); end
    run_to(299);
    checks++; if (an !== 4'b1101) begin errors++; $display("FAIL z0_d1_an: got %b expected %b", an, 4'b1101); end
  endtask
`endif

  // Reset in the show window of digit 1 while digit 9s are active and a new
  // value is pending.
  task automatic test_reset_mid();
    run_to(299);
    do_load(16'h9999, 4'b0000);
    run_to(330);
    do_load(16'h4321, 4'b0000);
    checks++; if (an !== 4'b1101) begin errors++; $display("FAIL rmid_pre_an: got %b expected %b", an, 4'b1101); end
    checks++; if (seg !== 7'b0000100) begin errors++; $display("FAIL rmid_pre_seg: got %b expected %b", seg, 7'b0000100); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_edge = 0;
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rmid_an: got %b expected %b", an, 4'b1111); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL rmid_seg: got %b expected %b", seg, 7'b1111111); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rmid_pending: got %b expected %b", pending, 1'b0); end
    checks++; if (nib_out !== 4'h0) begin errors++; $display("FAIL rmid_nib: got %h expected %h", nib_out, 4'h0); end
    run_to(2);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rmid_dead_an: got %b expected %b", an, 4'b1111); end
    run_to(3);
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rmid_first_an: got %b expected %b", an, 4'b1110); end
    checks++; if (seg !== 7'b0000001) begin errors++; $display("FAIL rmid_first_seg: got %b expected %b", seg, 7'b0000001); end
    run_to(32);
    checks++; if (frame !== 1'b1) begin errors++; $display("FAIL rmid_frame: got %b expected %b", frame, 1'b1); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_midframe();
    test_back_to_back();
    test_load_on_wrap();
    test_blank_mask();
    test_enable();
`ifdef SEG_SCAN_LZ_BLANK_EN
    test_lz_blank();
`else
    test_zeros_shown();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", n_edge);
    $fatal(1);
  end

endmodule
